// File: rtl/network_sdiv_30s_16s_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : network_sdiv_30s_16s_16_seq
// Description : Sequential 30s/16s signed divider (restoring, 1 bit per cycle)
//               with truncation toward zero, overflow and divide-by-zero flags.
//               Optional macro NETWORK_SDIV_SATURATE_EN clamps dout on
//               overflow / divide-by-zero instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module network_sdiv_30s_16s_16_seq #(
    parameter logic [31:0] ID = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic [29:0] din0,
    input  logic [15:0] din1,
    output logic        ready,
    output logic        done,
    output logic [15:0] dout,
    output logic [15:0] rem,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST_STEP = 5'd29;

    // ID is an instance tag only; this empty block just anchors the parameter.
    if (ID == 32'd0) begin : g_id_tag
    end

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [29:0] r_quo;     // dividend bits shift out, quotient bits shift in
    logic [15:0] r_rem;
    logic [15:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic [29:0] w_a_mag;
    logic [15:0] w_b_mag;
    logic [16:0] w_shift;
    logic [15:0] w_diff;
    logic        w_ge;
    logic        w_ovf;
    logic [15:0] w_q_wrap;
    logic [15:0] w_q_out;
    logic [15:0] w_r_out;

    always_comb begin
        w_a_mag  = din0[29] ? (~din0 + 30'd1) : din0;
        w_b_mag  = din1[15] ? (~din1 + 16'd1) : din1;
        w_shift  = {r_rem, r_quo[29]};
        w_ge     = (w_shift >= {1'b0, r_dvs});
        // When w_ge holds the true difference is below the divisor, so 16 bits suffice.
        w_diff   = w_shift[15:0] - r_dvs;
        w_q_wrap = r_neg_q ? (~r_quo[15:0] + 16'd1) : r_quo[15:0];
        w_ovf    = r_neg_q ? (r_quo > 30'd32768) : (r_quo > 30'd32767);
        w_r_out  = r_neg_r ? (~r_rem + 16'd1) : r_rem;
`ifdef NETWORK_SDIV_SATURATE_EN
        if (r_dz || w_ovf) begin
            w_q_out = r_neg_q ? 16'h8000 : 16'h7FFF;
        end else begin
            w_q_out = w_q_wrap;
        end
`else
        w_q_out = r_dz ? 16'hFFFF : w_q_wrap;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_quo   <= 30'd0;
            r_rem   <= 16'd0;
            r_dvs   <= 16'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            dout    <= 16'd0;
            rem     <= 16'd0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
        end else if (ce) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_rem   <= 16'd0;
                        r_cnt   <= 5'd0;
                        r_neg_r <= din0[29];
                        r_dz    <= (din1 == 16'd0);
                        ready   <= 1'b0;
                        // Divide-by-zero carries only the dividend sign and skips the iterations.
                        if (din1 == 16'd0) begin
                            r_neg_q <= din0[29];
                            r_state <= S_FIX;
                        end else begin
                            r_neg_q <= din0[29] ^ din1[15];
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_quo <= {r_quo[28:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_shift[15:0];
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    dout    <= w_q_out;
                    rem     <= w_r_out;
                    ovf     <= r_dz | w_ovf;
                    dz      <= r_dz;
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_network_sdiv_30s_16s_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_sdiv_30s_16s_16_seq
// Description : Self-checking bench for network_sdiv_30s_16s_16_seq against an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_sdiv_30s_16s_16_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [29:0] din0;
    logic [15:0] din1;
    logic        ready;
    logic        done;
    logic [15:0] dout;
    logic [15:0] rem;
    logic        ovf;
    logic        dz;

    int errs;
    int checks;

    network_sdiv_30s_16s_16_seq #(.ID(32'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic (SV / and % truncate toward zero).
    function automatic void model(input logic [29:0] a, input logic [15:0] b,
                                  output logic [15:0] q16, output logic [15:0] r16,
                                  output logic ovf_e, output logic dz_e);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            dz_e  = 1'b1;
            ovf_e = 1'b1;
            r16   = 16'd0;
`ifdef NETWORK_SDIV_SATURATE_EN
            q16 = (sa >= 0) ? 16'h7FFF : 16'h8000;
`else
            q16 = 16'hFFFF;
`endif
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            dz_e  = 1'b0;
            ovf_e = (q > 32767) || (q < -32768);
            r16   = r[15:0];
`ifdef NETWORK_SDIV_SATURATE_EN
            if (q > 32767)       q16 = 16'h7FFF;
            else if (q < -32768) q16 = 16'h8000;
            else                 q16 = q[15:0];
`else
            q16 = q[15:0];
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [29:0] a, input logic [15:0] b, input int gap_at,
                          input int gap_len, input bit poke, input bit idle_after);
        logic [15:0] eq, er;
        logic        eo, ez;
        int          n;
        model(a, b, eq, er, eo, ez);
        check("ready_before", {31'd0, ready}, 32'd1);
        din0  = a;
        din1  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        while (done !== 1'b1 && n < 300) begin
            ce = !(gap_len > 0 && n >= gap_at && n < gap_at + gap_len);
            if (poke && n == 8) begin
                start = 1'b1;
                din0  = 30'd5;
                din1  = 16'd1;
                check("ready_busy", {31'd0, ready}, 32'd0);
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        ce    = 1'b1;
        start = 1'b0;
        if (!ez) check("latency", n, 32 + gap_len);
        else     check("dz_done", {31'd0, done}, 32'd1);
        check("dout", {16'd0, dout}, {16'd0, eq});
        check("rem", {16'd0, rem}, {16'd0, er});
        check("ovf", {31'd0, ovf}, {31'd0, eo});
        check("dz", {31'd0, dz}, {31'd0, ez});
        check("ready_done", {31'd0, ready}, 32'd1);
        if (idle_after) begin
            tick();
            check("done_pulse", {31'd0, done}, 32'd0);
            check("dout_hold", {16'd0, dout}, {16'd0, eq});
            check("rem_hold", {16'd0, rem}, {16'd0, er});
        end
    endtask

    initial begin
        logic [31:0] ra, rb, mode;
        logic [29:0] a;
        logic [15:0] b;
        bit          seen;
        errs   = 0;
        checks = 0;
        reset  = 1'b0;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = 30'd0;
        din1   = 16'd0;
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_flags", {30'd0, ovf, dz}, 32'd0);
        reset = 1'b1;
        tick();

        run_op(30'd1000, 16'd7, 0, 0, 1'b0, 1'b1);
        run_op(-30'sd1000, 16'd7, 0, 0, 1'b0, 1'b0);
        run_op(30'd1000, -16'sd7, 0, 0, 1'b0, 1'b1);
        run_op(30'd100000, 16'd1, 0, 0, 1'b0, 1'b1);
        run_op(-30'sd5, 16'd0, 0, 0, 1'b0, 1'b1);
        run_op(30'd1000, 16'd7, 10, 5, 1'b1, 1'b1);
        run_op(30'h2000_0000, 16'h8000, 0, 0, 1'b0, 1'b0);
        run_op(30'h2000_0000, 16'hFFFF, 0, 0, 1'b0, 1'b1);
        run_op(30'h1FFF_FFFF, 16'h8000, 0, 0, 1'b0, 1'b1);
        run_op(30'd98301, -16'sd3, 0, 0, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        din0  = 30'd1000;
        din1  = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        check("mid_rst_dout", {16'd0, dout}, 32'd0);
        check("mid_rst_rem", {16'd0, rem}, 32'd0);
        check("mid_rst_flags", {29'd0, ovf, dz, done}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (done) seen = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done) seen = 1'b1;
        end
        check("rst_no_done", {31'd0, seen}, 32'd0);
        run_op(30'd1000, 16'd7, 0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra   = $urandom();
            rb   = $urandom();
            mode = $urandom_range(0, 4);
            a    = ra[29:0];
            if (mode == 0) a = {{14{ra[29]}}, ra[15:0]};
            case (mode)
                0, 1:    b = rb[15:0];
                2:       b = rb[31] ? -16'($urandom_range(1, 300)) : 16'($urandom_range(1, 300));
                3:       b = 16'h8000;
                default: b = rb[0] ? 16'hFFFF : 16'd0;
            endcase
            run_op(a, b, (i % 3 == 0) ? $urandom_range(2, 28) : 0,
                   (i % 3 == 0) ? $urandom_range(1, 4) : 0, 1'b0, rb[2]);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
